// File: rtl/rl_pair_dispatcher_pkg.sv
// Shared constants and helpers for the RL pair dispatcher.
// FSM encodings are plain localparam vectors so legacy netlists keep the same state codes.
package rl_pair_dispatcher_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    localparam int unsigned DEF_NUM_PIPE       = 4;
    localparam int unsigned DEF_REF_ADDR_WIDTH = 7;
    localparam int unsigned DEF_NBR_ADDR_WIDTH = 7;

    function automatic int unsigned lane_idx_width(input int unsigned num_pipe);
        return (num_pipe > 1) ? $clog2(num_pipe) : 1;
    endfunction

    // One bit of headroom above the wider count so sums never wrap in compares.
    function automatic int unsigned cmp_width(input int unsigned a, input int unsigned b);
        return ((a > b) ? a : b) + 1;
    endfunction

endpackage

// File: rtl/rl_pair_dispatcher_if.sv
// Position-RAM read bus between the pair dispatcher and the force lanes.
interface rl_pair_dispatcher_if #(
    parameter int unsigned NUM_PIPE       = 4,
    parameter int unsigned REF_ADDR_WIDTH = 7,
    parameter int unsigned NBR_ADDR_WIDTH = 7
);
    logic [REF_ADDR_WIDTH-1:0]          home_rdaddr;
    logic [NUM_PIPE*NBR_ADDR_WIDTH-1:0] nbr_rdaddr;
    logic                               rden;
    logic [NUM_PIPE-1:0]                lane_valid;
    logic                               stall;

    modport master (
        output home_rdaddr, nbr_rdaddr, rden, lane_valid,
        input  stall
    );

    modport slave (
        input  home_rdaddr, nbr_rdaddr, rden, lane_valid,
        output stall
    );
endinterface

// File: rtl/rl_pair_dispatcher_drain_timer.sv
// Counts unstalled drain cycles; expire marks the last of PIPE_LATENCY such cycles.
module rl_drain_timer #(
    parameter int unsigned PIPE_LATENCY = 31,
    parameter int unsigned DRAIN_WIDTH  = 6
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic en,
    input  logic stall,
    output logic expire
);
    localparam logic [DRAIN_WIDTH-1:0] LAST = DRAIN_WIDTH'(PIPE_LATENCY - 1);

    logic [DRAIN_WIDTH-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= '0;
        end else if (en && !stall) begin
            cnt <= cnt + DRAIN_WIDTH'(1);
        end
    end

    assign expire = en && !stall && (cnt == LAST);
endmodule

// File: rtl/rl_pair_dispatcher.sv
// Multi-lane (home, neighbor) pair sweep feeding NUM_PIPE force pipelines.
// Optional RL_DISPATCH_NEWTON3_EN: same-cell runs issue each unordered pair once.
module rl_pair_dispatcher
    import rl_pair_dispatcher_pkg::*;
#(
    parameter int unsigned NUM_PIPE       = 4,
    parameter int unsigned REF_ADDR_WIDTH = 7,
    parameter int unsigned NBR_ADDR_WIDTH = 7,
    parameter int unsigned PIPE_LATENCY   = 31,
    parameter int unsigned DRAIN_WIDTH    = 6
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [REF_ADDR_WIDTH:0]   ref_count,
    input  logic [NBR_ADDR_WIDTH:0]   nbr_count,
    input  logic                      same_cell,
    rl_pair_dispatcher_if.master      bus,
    output logic                      busy,
    output logic                      done
);
    localparam int unsigned NW1 = NBR_ADDR_WIDTH + 1;
    localparam int unsigned RW1 = REF_ADDR_WIDTH + 1;
    localparam int unsigned CW  = cmp_width(RW1, NW1);

    logic [1:0]                         state;
    logic [REF_ADDR_WIDTH-1:0]          home;
    logic [NW1-1:0]                     base;
    logic [RW1-1:0]                     ref_q;
    logic [NW1-1:0]                     nbr_q;
    logic [NUM_PIPE-1:0]                mask;
    logic [NUM_PIPE-1:0]                lane_valid_q;
    logic [NUM_PIPE*NBR_ADDR_WIDTH-1:0] nbr_addr;

    logic n3, n3_start;
    logic issue, beat;
    logic group_end, row_last, next_row_empty, sweep_end, start_empty;
    logic drain_load, drain_en, drain_expire;
    logic [NW1-1:0] row_base_next, row_base_first;

`ifdef RL_DISPATCH_NEWTON3_EN
    logic n3_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            n3_q <= 1'b0;
        end else if (state == ST_IDLE && start) begin
            n3_q <= same_cell;
        end
    end

    assign n3       = n3_q;
    assign n3_start = same_cell;
`else
    logic unused_same_cell;
    assign unused_same_cell = same_cell;
    assign n3               = 1'b0;
    assign n3_start         = 1'b0;
`endif

    assign issue = (state == ST_ISSUE);
    assign beat  = issue && !bus.stall;

    assign group_end      = (CW'(base) + CW'(NUM_PIPE)) >= CW'(nbr_q);
    assign row_last       = (CW'(home) + CW'(1)) >= CW'(ref_q);
    // Same-cell rows start at home+1, so once a row is empty every later row is too.
    assign next_row_empty = n3 && ((CW'(home) + CW'(2)) >= CW'(nbr_q));
    assign sweep_end      = row_last || next_row_empty;
    assign row_base_next  = n3 ? (NW1'(home) + NW1'(2)) : '0;
    assign row_base_first = n3_start ? NW1'(1) : '0;
    assign start_empty    = (ref_count == '0) || (nbr_count == '0) ||
                            (n3_start && (nbr_count <= NW1'(1)));

    for (genvar k = 0; k < NUM_PIPE; k++) begin : g_lane
        logic [NW1-1:0] addr_k;
        assign addr_k = base + NW1'(k);
        assign nbr_addr[k*NBR_ADDR_WIDTH +: NBR_ADDR_WIDTH] =
            issue ? addr_k[NBR_ADDR_WIDTH-1:0] : '0;
        assign mask[k] = (addr_k < nbr_q) && (!n3 || (CW'(addr_k) > CW'(home)));
    end

    assign drain_load = beat && group_end && sweep_end;
    assign drain_en   = (state == ST_DRAIN);

    rl_drain_timer #(
        .PIPE_LATENCY (PIPE_LATENCY),
        .DRAIN_WIDTH  (DRAIN_WIDTH)
    ) u_drain (
        .clk    (clk),
        .rst    (rst),
        .load   (drain_load),
        .en     (drain_en),
        .stall  (bus.stall),
        .expire (drain_expire)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state        <= ST_IDLE;
            home         <= '0;
            base         <= '0;
            ref_q        <= '0;
            nbr_q        <= '0;
            lane_valid_q <= '0;
        end else begin
            lane_valid_q <= beat ? mask : '0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        ref_q <= ref_count;
                        nbr_q <= nbr_count;
                        home  <= '0;
                        base  <= row_base_first;
                        state <= start_empty ? ST_DONE : ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (!bus.stall) begin
                        if (!group_end) begin
                            base <= base + NW1'(NUM_PIPE);
                        end else if (sweep_end) begin
                            state <= ST_DRAIN;
                        end else begin
                            home <= home + REF_ADDR_WIDTH'(1);
                            base <= row_base_next;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (drain_expire) begin
                        state <= ST_DONE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.home_rdaddr = issue ? home : '0;
    assign bus.nbr_rdaddr  = nbr_addr;
    assign bus.rden        = beat;
    assign bus.lane_valid  = lane_valid_q;
    assign busy            = issue || (state == ST_DRAIN);
    assign done            = (state == ST_DONE);
endmodule

// File: tb/tb_rl_pair_dispatcher.sv
// Bench for rl_pair_dispatcher: table-driven runs, scripted corner sequences and random runs
// checked against a pair-list reference model.
module tb_rl_pair_dispatcher;
    localparam int NP  = 4;
    localparam int RAW = 7;
    localparam int NAW = 7;
    localparam int PL  = 31;

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic           start = 1'b0;
    logic           same_cell = 1'b0;
    logic [RAW:0]   ref_count = '0;
    logic [NAW:0]   nbr_count = '0;
    logic           busy, done;

    rl_pair_dispatcher_if #(.NUM_PIPE(NP), .REF_ADDR_WIDTH(RAW), .NBR_ADDR_WIDTH(NAW)) bus ();

    rl_pair_dispatcher #(
        .NUM_PIPE       (NP),
        .REF_ADDR_WIDTH (RAW),
        .NBR_ADDR_WIDTH (NAW),
        .PIPE_LATENCY   (PL),
        .DRAIN_WIDTH    (6)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .ref_count (ref_count),
        .nbr_count (nbr_count),
        .same_cell (same_cell),
        .bus       (bus),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    typedef struct {
        int            h;
        int            b;
        logic [NP-1:0] m;
    } beat_t;

    beat_t         exp_q[$];
    int            last_addr[NP];
    logic [NP-1:0] last_mask;

    // Reference: enumerate every (home, neighbor-group) the sweep should issue.
    function automatic void build(input int rc, input int nc, input bit n3);
        beat_t e;
        exp_q.delete();
        for (int h = 0; h < rc; h++) begin
            for (int b = (n3 ? h + 1 : 0); b < nc; b += NP) begin
                e.h = h;
                e.b = b;
                for (int k = 0; k < NP; k++)
                    e.m[k] = (b + k < nc) && (!n3 || (b + k > h));
                exp_q.push_back(e);
            end
        end
    endfunction

    task automatic run(input int rc, input int nc, input bit sc, input int mode,
                       output int beats, output int lanes, output int cyc);
        bit            n3;
        bit            seen_done;
        bit            nxt;
        logic [NP-1:0] prev_m;
        int            drain_cnt, s1, s2;
        beat_t         e;
`ifdef RL_DISPATCH_NEWTON3_EN
        n3 = sc;
`else
        n3 = 1'b0;
`endif
        build(rc, nc, n3);
        beats = 0; lanes = 0; cyc = 0; prev_m = '0;
        drain_cnt = 0; s1 = 0; s2 = 0; seen_done = 0; nxt = 0;
        @(negedge clk);
        ref_count = (RAW+1)'(rc);
        nbr_count = (NAW+1)'(nc);
        same_cell = sc;
        start     = 1'b1;
        bus.stall = 1'b0;
        while (!seen_done && cyc < 20000) begin
            @(posedge clk);
            #1;
            if (cyc == 0) begin
                start     = 1'b0;
                ref_count = (RAW+1)'($urandom);
                nbr_count = (NAW+1)'($urandom);
                same_cell = 1'($urandom);
            end
            bus.stall = nxt;
            @(negedge clk);
            cyc++;
            chk("lane_valid", bus.lane_valid, prev_m);
            if (bus.rden) begin
                chk("rden_busy", busy, 1);
                if (exp_q.size() == 0) begin
                    chk("extra_beat", 1, 0);
                    prev_m = '0;
                end else begin
                    e = exp_q.pop_front();
                    chk("home_addr", bus.home_rdaddr, e.h);
                    for (int k = 0; k < NP; k++) begin
                        chk("nbr_addr", bus.nbr_rdaddr[k*NAW +: NAW], (e.b + k) % (1 << NAW));
                        last_addr[k] = (e.b + k) % (1 << NAW);
                    end
                    prev_m    = e.m;
                    last_mask = e.m;
                    beats++;
                    lanes    += $countones(e.m);
                    drain_cnt = 0;
                end
            end else begin
                prev_m = '0;
                if (busy && bus.stall && exp_q.size() > 0) begin
                    chk("hold_home", bus.home_rdaddr, exp_q[0].h);
                    chk("hold_nbr0", bus.nbr_rdaddr[NAW-1:0], exp_q[0].b % (1 << NAW));
                end
                if (busy && !bus.stall) begin
                    if (exp_q.size() > 0) chk("issue_no_beat", 0, 1);
                    else drain_cnt++;
                end
            end
            if (done) begin
                seen_done = 1;
                chk("done_q_empty", exp_q.size(), 0);
                chk("done_busy", busy, 0);
                chk("drain_len", drain_cnt, (beats > 0) ? PL : 0);
                if (beats == 0) chk("empty_done_latency", cyc <= 2, 1);
            end
            case (mode)
                1: nxt = ($urandom_range(0, 3) == 0);
                2: begin
                    if (beats == 2 && s1 < 5 && exp_q.size() > 0) begin
                        nxt = 1; s1++;
                    end else if (exp_q.size() == 0 && drain_cnt == 10 && s2 < 3 && !bus.rden) begin
                        nxt = 1; s2++;
                    end else begin
                        nxt = 0;
                    end
                end
                default: nxt = 0;
            endcase
        end
        if (!seen_done) begin
            chk("done_timeout", 0, 1);
        end else begin
            @(posedge clk);
            #1 bus.stall = 1'b0;
            @(negedge clk);
            chk("done_one_cycle", done, 0);
            chk("lane_valid_idle", bus.lane_valid, 0);
            chk("busy_idle", busy, 0);
        end
        bus.stall = 1'b0;
    endtask

    typedef struct {
        int rc;
        int nc;
        int mode;
        int exp_beats;
        int exp_lanes;
    } vec_t;

    initial begin
        #800000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vec_t tbl[9];
        int   beats, lanes, cyc, c0, c2, nb, lim, dcount, bcount;

        tbl[0] = '{2,   8,   0, 4,   16};
        tbl[1] = '{1,   6,   0, 2,   6};
        tbl[2] = '{0,   5,   0, 0,   0};
        tbl[3] = '{3,   0,   0, 0,   0};
        tbl[4] = '{3,   5,   1, 6,   15};
        tbl[5] = '{1,   1,   0, 1,   1};
        tbl[6] = '{2,   128, 0, 64,  256};
        tbl[7] = '{128, 1,   1, 128, 128};
        tbl[8] = '{1,   4,   1, 1,   4};

        bus.stall = 1'b0;
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_rden", bus.rden, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_lane_valid", bus.lane_valid, 0);
        chk("rst_home", bus.home_rdaddr, 0);
        chk("rst_nbr", bus.nbr_rdaddr, 0);
        rst = 1'b1;

        for (int i = 0; i < 9; i++) begin
            run(tbl[i].rc, tbl[i].nc, 1'b0, tbl[i].mode, beats, lanes, cyc);
            chk("tbl_beats", beats, tbl[i].exp_beats);
            chk("tbl_lanes", lanes, tbl[i].exp_lanes);
            if (tbl[i].rc == 1 && tbl[i].nc == 6) begin
                chk("partial_mask", last_mask, 4'b0011);
                for (int k = 0; k < NP; k++) chk("partial_addr", last_addr[k], 4 + k);
            end
        end

        // Stall 5 cycles mid-issue and 3 in drain: identical beats, done 8 cycles later.
        run(2, 8, 1'b0, 0, beats, lanes, c0);
        run(2, 8, 1'b0, 2, beats, lanes, c2);
        chk("stall_beats", beats, 4);
        chk("stall_delay", c2, c0 + 8);

        // Reset in the middle of the drain.
        @(negedge clk);
        ref_count = 8'd2; nbr_count = 8'd8; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        nb = 0; lim = 0;
        while (nb < 4 && lim < 200) begin
            if (bus.rden) nb++;
            lim++;
            @(negedge clk);
        end
        chk("pre_reset_beats", nb, 4);
        repeat (5) @(negedge clk);
        chk("pre_reset_busy", busy, 1);
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_busy", busy, 0);
        chk("midrst_done", done, 0);
        chk("midrst_rden", bus.rden, 0);
        chk("midrst_lane_valid", bus.lane_valid, 0);
        chk("midrst_home", bus.home_rdaddr, 0);
        chk("midrst_nbr", bus.nbr_rdaddr, 0);
        rst = 1'b1;
        dcount = 0; bcount = 0;
        repeat (40) begin
            @(negedge clk);
            if (done) dcount++;
            if (busy) bcount++;
        end
        chk("midrst_no_done", dcount, 0);
        chk("midrst_no_busy", bcount, 0);
        run(1, 6, 1'b0, 0, beats, lanes, cyc);
        chk("post_rst_lanes", lanes, 6);

`ifdef RL_DISPATCH_NEWTON3_EN
        run(4, 4, 1'b1, 0, beats, lanes, cyc);
        chk("n3_lanes", lanes, 6);
        chk("n3_beats", beats, 3);
        run(3, 9, 1'b1, 1, beats, lanes, cyc);
        chk("n3_wide_lanes", lanes, 8 + 7 + 6);
        run(3, 1, 1'b1, 0, beats, lanes, cyc);
        chk("n3_empty_beats", beats, 0);
`endif

        for (int r = 0; r < 12; r++) begin
            run($urandom_range(0, 9), $urandom_range(0, 20), 1'($urandom), 1, beats, lanes, cyc);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
